rv_multicycle_ctrl: RTL and testbench
=====================================

Name: rv_multicycle_ctrl

Overview:
- Multicycle sequencer for the RV32I core. Drives a shared-memory, single-ALU datapath: PC, IR, old-PC, A/B and ALUOut registers, with one unified instruction/data memory port.
- Replaces the single-cycle control path. Reads the latched opcode and steps each instruction through fetch, decode, execute, memory and writeback states.
- Handles memory wait states through a req/ready handshake.
- Counts retired instructions and traps on illegal opcodes.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous reset, active-high
- op_code  in  7  IR[6:0], valid from DECODE onward
- branch_taken  in  1  branch condition from the datapath comparator, for the current funct3
- mem_ready  in  1  memory completes the access this cycle
- mem_req  out  1  memory access request
- mem_we  out  1  write strobe; qualified by mem_req
- adr_src  out  1  memory address: 0 = PC, 1 = ALUOut
- ir_write  out  1  load IR and old-PC
- pc_write  out  1  load PC from the result mux
- reg_w  out  1  register-file write enable
- alu_src_a  out  2  00 = PC, 01 = old-PC, 10 = A (rs1), 11 = zero
- alu_src_b  out  2  00 = B (rs2), 01 = imm, 10 = constant 4
- alu_op  out  2  00 = add, 01 = sub/branch compare, 10 = funct-decoded
- result_src  out  2  00 = ALUOut, 01 = memory read data, 10 = ALU result
- illegal  out  1  sticky trap flag
- instret  out  CNT_W  retired-instruction count

Behaviour:
- Reset:
  - rst high at a clk edge sets state = FETCH and instret = 0; this takes priority over every other event.
  - While rst is high, all outputs are forced to 0.
  - Reset mid-instruction, including mid-wait, abandons the instruction; it is not counted.
- Output style:
  - Outputs are decoded from the state register, except that pc_write and ir_write may also depend on mem_ready or branch_taken, as listed per state.
  - Any output not listed for a state is 0.
- States, outputs and next state:
  - FETCH: mem_req=1, adr_src=0, a=00, b=10, alu_op=00, result_src=10.
    - mem_ready=1: ir_write=1, pc_write=1, go to DECODE.
    - mem_ready=0: stay in FETCH with requests held stable.
  - DECODE: a=01, b=01, alu_op=00 (ALUOut = old-PC + imm). Next state by op_code:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXECR
    - 0010011 -> EXECI
    - 1100011 -> BRANCH
    - 1101111 -> JAL
    - 1100111 -> JALR
    - 0110111 -> LUI
    - 0010111 -> ALUWB (ALUOut already holds the AUIPC value)
    - any other opcode -> TRAP
  - MEMADR: a=10, b=01, alu_op=00. Go to MEMREAD for a load, MEMWRITE for a store.
  - MEMREAD: mem_req=1, adr_src=1. Wait for mem_ready, then go to MEMWB.
  - MEMWB: result_src=01, reg_w=1. Go to FETCH.
  - MEMWRITE: mem_req=1, mem_we=1, adr_src=1. Wait for mem_ready, then go to FETCH.
  - EXECR: a=10, b=00, alu_op=10. Go to ALUWB.
  - EXECI: a=10, b=01, alu_op=10. Go to ALUWB.
  - LUI: a=11, b=01, alu_op=00. Go to ALUWB.
  - ALUWB: result_src=00, reg_w=1. Go to FETCH.
  - BRANCH: a=10, b=00, alu_op=01, result_src=00, pc_write=branch_taken. Go to FETCH.
  - JALR: a=10, b=01, alu_op=00 (ALUOut = rs1 + imm). Go to JAL.
  - JAL: a=01, b=10, alu_op=00, result_src=00, pc_write=1. The PC takes the target; the ALU computes old-PC + 4 into ALUOut. Go to ALUWB.
  - TRAP: illegal=1, all other outputs 0. Stays in TRAP until rst.
- Retired-instruction counter:
  - instret increments by 1 on every transition into FETCH from a non-FETCH state.
  - It wraps modulo 2^CNT_W.
  - It is never incremented by TRAP, by reset, or by FETCH wait cycles.
- Memory handshake:
  - mem_req, mem_we and adr_src stay constant until the cycle in which mem_ready=1.
  - mem_ready is ignored in states that do not assert mem_req.
- Latency with zero wait states:
  - load 5 cycles; store 4; R-type and I-type 4; LUI 4; AUIPC 3; branch 3; JAL 4; JALR 5.
  - Each wait cycle adds one cycle.

Test Plan:
- Reset, then fetch: hold rst for 2 cycles, then release with mem_ready=1. All outputs are 0 during reset. The first cycle after release is FETCH with mem_req=1, pc_write=1, ir_write=1; instret=0.
- add x3,x1,x2 (0x002081B3), zero wait: state sequence FETCH, DECODE, EXECR, ALUWB. reg_w=1 only in cycle 4 with result_src=00. instret goes 0 -> 1 on re-entering FETCH.
- lw with mem_ready low for 3 cycles in MEMREAD: mem_req=1 and adr_src=1 hold for 4 cycles. MEMWB follows with result_src=01, reg_w=1. Total latency 8 cycles.
- beq with branch_taken=0, then again with branch_taken=1: pc_write=0 in BRANCH for the first and pc_write=1 for the second. Both take 3 cycles and both increment instret.
- jalr (op_code 1100111): state sequence DECODE, JALR (a=10, b=01), JAL (pc_write=1, a=01, b=10), ALUWB (reg_w=1).
- Illegal opcode 0x7F: TRAP is entered after DECODE. illegal=1 and all strobes stay 0 for 10 or more cycles; instret is unchanged. rst clears illegal.

Source files
------------

// File: rtl/rv_multicycle_ctrl.sv
// Multicycle control sequencer for an RV32I shared-memory datapath.
// State is registered; datapath strobes are decoded from the current state.
module rv_multicycle_ctrl #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       op_code,
  input  logic             branch_taken,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             adr_src,
  output logic             ir_write,
  output logic             pc_write,
  output logic             reg_w,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       result_src,
  output logic             illegal,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR,
    S_EXECI, S_LUI, S_ALUWB, S_BRANCH, S_JALR, S_JAL, S_TRAP
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] instret_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH:    if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        unique case (op_code)
          7'b0000011, 7'b0100011: state_d = S_MEMADR;
          7'b0110011:             state_d = S_EXECR;
          7'b0010011:             state_d = S_EXECI;
          7'b1100011:             state_d = S_BRANCH;
          7'b1101111:             state_d = S_JAL;
          7'b1100111:             state_d = S_JALR;
          7'b0110111:             state_d = S_LUI;
          7'b0010111:             state_d = S_ALUWB;
          default:                state_d = S_TRAP;
        endcase
      end
      S_MEMADR:   state_d = (op_code == 7'b0100011) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_LUI:      state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_JALR:     state_d = S_JAL;
      S_JAL:      state_d = S_ALUWB;
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_FETCH;
    endcase
  end

  // An instruction retires on any entry into FETCH from another state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_d == S_FETCH && state_q != S_FETCH)
        instret_q <= instret_q + CNT_W'(1);
    end
  end

  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_w      = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    result_src = 2'b00;
    illegal    = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_w      = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        adr_src = 1'b1;
      end
      S_EXECR: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
      end
      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
      end
      S_LUI: begin
        alu_src_a = 2'b11;
        alu_src_b = 2'b01;
      end
      S_ALUWB:    reg_w = 1'b1;
      S_BRANCH: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        pc_write  = branch_taken;
      end
      S_JALR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
      end
      S_TRAP:     illegal = 1'b1;
      default: ;
    endcase
    if (rst) begin
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      adr_src    = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      reg_w      = 1'b0;
      alu_src_a  = 2'b00;
      alu_src_b  = 2'b00;
      alu_op     = 2'b00;
      result_src = 2'b00;
      illegal    = 1'b0;
    end
  end

  assign instret = rst ? '0 : instret_q;

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// Scoreboard bench for rv_multicycle_ctrl: stimulus queues the expected
// strobes per cycle, a negedge monitor pops and compares.
module tb_rv_multicycle_ctrl;

  typedef enum int {
    T_RST, T_FETCH, T_DECODE, T_MEMADR, T_MEMREAD, T_MEMWB, T_MEMWRITE,
    T_EXECR, T_EXECI, T_LUI, T_ALUWB, T_BRANCH, T_JALR, T_JAL, T_TRAP
  } tst_e;

  typedef struct {
    logic [14:0] ctl;
    logic [31:0] cnt;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  op_code = '0;
  logic        branch_taken = 1'b0;
  logic        mem_ready = 1'b0;
  logic        mem_req, mem_we, adr_src, ir_write, pc_write, reg_w, illegal;
  logic [1:0]  alu_src_a, alu_src_b, alu_op, result_src;
  logic [31:0] instret;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  rv_multicycle_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst), .op_code(op_code), .branch_taken(branch_taken),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
    .adr_src(adr_src), .ir_write(ir_write), .pc_write(pc_write),
    .reg_w(reg_w), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .result_src(result_src), .illegal(illegal),
    .instret(instret)
  );

  always #5 clk = ~clk;

  // {req, we, adr, ir_w, pc_w, reg_w, a, b, alu_op, res, illegal}
  function automatic logic [14:0] ctl(input tst_e s, input logic rdy, input logic tk);
    case (s)
      T_FETCH:    return {1'b1, 1'b0, 1'b0, rdy, rdy, 1'b0, 2'b00, 2'b10, 2'b00, 2'b10, 1'b0};
      T_DECODE:   return {6'b000000, 2'b01, 2'b01, 2'b00, 2'b00, 1'b0};
      T_MEMADR:   return {6'b000000, 2'b10, 2'b01, 2'b00, 2'b00, 1'b0};
      T_MEMREAD:  return {6'b101000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
      T_MEMWB:    return {6'b000001, 2'b00, 2'b00, 2'b00, 2'b01, 1'b0};
      T_MEMWRITE: return {6'b111000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
      T_EXECR:    return {6'b000000, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0};
      T_EXECI:    return {6'b000000, 2'b10, 2'b01, 2'b10, 2'b00, 1'b0};
      T_LUI:      return {6'b000000, 2'b11, 2'b01, 2'b00, 2'b00, 1'b0};
      T_ALUWB:    return {6'b000001, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
      T_BRANCH:   return {4'b0000, tk, 1'b0, 2'b10, 2'b00, 2'b01, 2'b00, 1'b0};
      T_JALR:     return {6'b000000, 2'b10, 2'b01, 2'b00, 2'b00, 1'b0};
      T_JAL:      return {6'b000010, 2'b01, 2'b10, 2'b00, 2'b00, 1'b0};
      T_TRAP:     return {14'b0, 1'b1};
      default:    return '0;
    endcase
  endfunction

  task automatic step(input tst_e s, input logic rdy, input logic tk,
                      input logic [6:0] op, input logic r, input int unsigned cnt,
                      input string nm);
    exp_t e;
    rst          = r;
    mem_ready    = rdy;
    branch_taken = tk;
    op_code      = op;
    e.ctl  = ctl(s, rdy, tk);
    e.cnt  = cnt;
    e.name = nm;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin : monitor
    exp_t        e;
    logic [14:0] got;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e   = q.pop_front();
        got = {mem_req, mem_we, adr_src, ir_write, pc_write, reg_w,
               alu_src_a, alu_src_b, alu_op, result_src, illegal};
        n_tests++;
        if (got !== e.ctl || instret !== e.cnt) begin
          n_fail++;
          $display("FAIL %s: ctl got %b want %b, instret got %0d want %0d",
                   e.name, got, e.ctl, instret, e.cnt);
        end
      end
    end
  end

  initial begin : stim
    @(posedge clk);
    #1;
    step(T_RST, 1'b0, 1'b0, 7'h00, 1'b1, 0, "rst_a");
    step(T_RST, 1'b1, 1'b1, 7'h7f, 1'b1, 0, "rst_b");
    // add x3,x1,x2
    step(T_FETCH,  1'b1, 1'b0, 7'h33, 1'b0, 0, "add_fetch");
    step(T_DECODE, 1'b0, 1'b0, 7'h33, 1'b0, 0, "add_decode");
    step(T_EXECR,  1'b1, 1'b0, 7'h33, 1'b0, 0, "add_execr");
    step(T_ALUWB,  1'b0, 1'b0, 7'h33, 1'b0, 0, "add_aluwb");
    // lw with three wait cycles
    step(T_FETCH,   1'b1, 1'b0, 7'h33, 1'b0, 1, "lw_fetch");
    step(T_DECODE,  1'b0, 1'b0, 7'h03, 1'b0, 1, "lw_decode");
    step(T_MEMADR,  1'b0, 1'b0, 7'h03, 1'b0, 1, "lw_memadr");
    for (int i = 0; i < 3; i++)
      step(T_MEMREAD, 1'b0, 1'b0, 7'h03, 1'b0, 1, "lw_memread_wait");
    step(T_MEMREAD, 1'b1, 1'b0, 7'h03, 1'b0, 1, "lw_memread_done");
    step(T_MEMWB,   1'b0, 1'b0, 7'h03, 1'b0, 1, "lw_memwb");
    // fetch wait cycles, then sw with one wait
    step(T_FETCH,    1'b0, 1'b0, 7'h03, 1'b0, 2, "sw_fetch_wait");
    step(T_FETCH,    1'b0, 1'b1, 7'h03, 1'b0, 2, "sw_fetch_wait2");
    step(T_FETCH,    1'b1, 1'b0, 7'h03, 1'b0, 2, "sw_fetch");
    step(T_DECODE,   1'b0, 1'b0, 7'h23, 1'b0, 2, "sw_decode");
    step(T_MEMADR,   1'b1, 1'b0, 7'h23, 1'b0, 2, "sw_memadr");
    step(T_MEMWRITE, 1'b0, 1'b0, 7'h23, 1'b0, 2, "sw_memwrite_wait");
    step(T_MEMWRITE, 1'b1, 1'b0, 7'h23, 1'b0, 2, "sw_memwrite_done");
    // beq not taken, then taken
    step(T_FETCH,  1'b1, 1'b0, 7'h23, 1'b0, 3, "beq0_fetch");
    step(T_DECODE, 1'b0, 1'b0, 7'h63, 1'b0, 3, "beq0_decode");
    step(T_BRANCH, 1'b1, 1'b0, 7'h63, 1'b0, 3, "beq0_branch");
    step(T_FETCH,  1'b1, 1'b0, 7'h63, 1'b0, 4, "beq1_fetch");
    step(T_DECODE, 1'b0, 1'b1, 7'h63, 1'b0, 4, "beq1_decode");
    step(T_BRANCH, 1'b0, 1'b1, 7'h63, 1'b0, 4, "beq1_branch");
    // jalr
    step(T_FETCH,  1'b1, 1'b0, 7'h63, 1'b0, 5, "jalr_fetch");
    step(T_DECODE, 1'b0, 1'b0, 7'h67, 1'b0, 5, "jalr_decode");
    step(T_JALR,   1'b0, 1'b0, 7'h67, 1'b0, 5, "jalr_jalr");
    step(T_JAL,    1'b0, 1'b0, 7'h67, 1'b0, 5, "jalr_jal");
    step(T_ALUWB,  1'b0, 1'b0, 7'h67, 1'b0, 5, "jalr_aluwb");
    // jal
    step(T_FETCH,  1'b1, 1'b0, 7'h67, 1'b0, 6, "jal_fetch");
    step(T_DECODE, 1'b0, 1'b0, 7'h6f, 1'b0, 6, "jal_decode");
    step(T_JAL,    1'b0, 1'b0, 7'h6f, 1'b0, 6, "jal_jal");
    step(T_ALUWB,  1'b0, 1'b0, 7'h6f, 1'b0, 6, "jal_aluwb");
    // lui
    step(T_FETCH,  1'b1, 1'b0, 7'h6f, 1'b0, 7, "lui_fetch");
    step(T_DECODE, 1'b0, 1'b0, 7'h37, 1'b0, 7, "lui_decode");
    step(T_LUI,    1'b0, 1'b0, 7'h37, 1'b0, 7, "lui_lui");
    step(T_ALUWB,  1'b0, 1'b0, 7'h37, 1'b0, 7, "lui_aluwb");
    // auipc
    step(T_FETCH,  1'b1, 1'b0, 7'h37, 1'b0, 8, "auipc_fetch");
    step(T_DECODE, 1'b0, 1'b0, 7'h17, 1'b0, 8, "auipc_decode");
    step(T_ALUWB,  1'b0, 1'b0, 7'h17, 1'b0, 8, "auipc_aluwb");
    // addi
    step(T_FETCH,  1'b1, 1'b0, 7'h17, 1'b0, 9, "addi_fetch");
    step(T_DECODE, 1'b0, 1'b0, 7'h13, 1'b0, 9, "addi_decode");
    step(T_EXECI,  1'b0, 1'b0, 7'h13, 1'b0, 9, "addi_execi");
    step(T_ALUWB,  1'b0, 1'b0, 7'h13, 1'b0, 9, "addi_aluwb");
    // illegal opcode traps until reset
    step(T_FETCH,  1'b1, 1'b0, 7'h13, 1'b0, 10, "ill_fetch");
    step(T_DECODE, 1'b0, 1'b0, 7'h7f, 1'b0, 10, "ill_decode");
    for (int i = 0; i < 12; i++)
      step(T_TRAP, 1'b1, 1'b1, 7'h7f, 1'b0, 10, "ill_trap");
    step(T_RST,   1'b1, 1'b0, 7'h7f, 1'b1, 0, "ill_rst");
    step(T_FETCH, 1'b1, 1'b0, 7'h7f, 1'b0, 0, "post_rst_fetch");
    step(T_DECODE, 1'b0, 1'b0, 7'h33, 1'b0, 0, "post_rst_decode");
    repeat (3) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: queue left %0d entries, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
